control_barrera: RTL and testbench

- Entry-barrier controller for the parking system; sits directly downstream of the vehicle counter.
- Consumes the occupancy count, the debounced sensor `a` and the one-cycle `ingreso` pulse.
- Drives the barrier motor and the entry traffic light, and supervises the motor with limit switches and timeouts.
- Refuses entry when the lot is full, reverses the barrier on an obstacle, and latches a fault alarm until it is acknowledged.

---
 rtl/control_barrera.sv | 124 ++++++++++++
 tb/tb_control_barrera.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_barrera.sv
// Entry-barrier controller: gates entry on lot occupancy, drives the barrier motor and
// traffic light, supervises strokes with limit switches and timeouts, latches faults.
module control_barrera #(
    parameter int CUPO_MAX = 7,
    parameter int T_MOTOR  = 50000000,
    parameter int T_ESPERA = 250000000,
    parameter int TW       = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] count,
    input  logic       solicitud,
    input  logic       a,
    input  logic       ingreso,
    input  logic       fin_abierta,
    input  logic       fin_cerrada,
    input  logic       reconocer,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       verde,
    output logic       rojo,
    output logic       rechazo,
    output logic       alarma,
    output logic [2:0] estado,
    output logic [7:0] aperturas
);

    typedef enum logic [2:0] {
        CERRADA  = 3'd0,
        ABRIENDO = 3'd1,
        ABIERTA  = 3'd2,
        CERRANDO = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    localparam logic [TW-1:0] TM_FIN = TW'(T_MOTOR - 1);
    localparam logic [TW-1:0] TE_FIN = TW'(T_ESPERA - 1);

    estado_t       st, st_nx;
    logic [TW-1:0] timer;
    logic          sol_prev;
    logic          rechazo_nx;
    logic          inc_ap;
    logic          sol_edge;
    logic          sw_both;
    logic          hay_cupo;
    logic          cuenta;

    assign sol_edge = solicitud & ~sol_prev;
    assign sw_both  = fin_abierta & fin_cerrada;
    assign hay_cupo = {29'd0, count} < 32'(CUPO_MAX);
    assign cuenta   = (st == ABRIENDO) || (st == ABIERTA) || (st == CERRANDO);

    always_comb begin
        st_nx      = st;
        rechazo_nx = 1'b0;
        inc_ap     = 1'b0;
        // Contradictory limit switches override every other transition.
        if (sw_both && st != FALLA) begin
            st_nx = FALLA;
        end else begin
            case (st)
                CERRADA: begin
                    if (sol_edge) begin
                        if (hay_cupo) begin
                            st_nx  = ABRIENDO;
                            inc_ap = 1'b1;
                        end else begin
                            rechazo_nx = 1'b1;
                        end
                    end
                end
                ABRIENDO: begin
                    if (fin_abierta)          st_nx = ABIERTA;
                    else if (timer == TM_FIN) st_nx = FALLA;
                end
                ABIERTA: begin
                    if (ingreso || timer == TE_FIN) st_nx = CERRANDO;
                end
                CERRANDO: begin
                    // Obstacle reversal outranks the closed switch.
                    if (a)                    st_nx = ABRIENDO;
                    else if (fin_cerrada)     st_nx = CERRADA;
                    else if (timer == TM_FIN) st_nx = FALLA;
                end
                FALLA: begin
                    if (reconocer && !sw_both) st_nx = CERRANDO;
                end
                default: st_nx = CERRADA;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= CERRADA;
            timer     <= '0;
            sol_prev  <= 1'b0;
            rechazo   <= 1'b0;
            aperturas <= 8'd0;
        end else begin
            st       <= st_nx;
            sol_prev <= solicitud;
            rechazo  <= rechazo_nx;
            if (inc_ap && aperturas != 8'hFF)
                aperturas <= aperturas + 8'd1;
            if (st_nx != st)
                timer <= '0;
            else if (cuenta)
                timer <= timer + 1'b1;
            else
                timer <= '0;
        end
    end

    // Moore decode straight off the state register so reset drops the motors at once.
    assign motor_abrir  = (st == ABRIENDO);
    assign motor_cerrar = (st == CERRANDO);
    assign verde        = (st == ABIERTA);
    assign rojo         = (st != ABIERTA);
    assign alarma       = (st == FALLA);
    assign estado       = st;

endmodule

// File: tb/tb_control_barrera.sv
// Randomized scenario bench for control_barrera; a rule-level model in the bench predicts
// state, rechazo and aperturas each cycle.
module tb_control_barrera;

    localparam int TM = 5;
    localparam int TE = 8;

    logic       clk = 0;
    logic       rst = 1;
    logic [2:0] count = 0;
    logic       solicitud = 0, a = 0, ingreso = 0, fin_abierta = 0, fin_cerrada = 0, reconocer = 0;
    logic       motor_abrir, motor_cerrar, verde, rojo, rechazo, alarma;
    logic [2:0] estado;
    logic [7:0] aperturas;

    int errors = 0;
    int checks = 0;

    // model state: 0 cerrada, 1 abriendo, 2 abierta, 3 cerrando, 4 falla
    int m_st = 0, m_tmr = 0, m_ap = 0;
    bit m_prev = 0, m_rech = 0;

    control_barrera #(.CUPO_MAX(7), .T_MOTOR(TM), .T_ESPERA(TE), .TW(28)) dut (
        .clk(clk), .rst(rst), .count(count), .solicitud(solicitud), .a(a), .ingreso(ingreso),
        .fin_abierta(fin_abierta), .fin_cerrada(fin_cerrada), .reconocer(reconocer),
        .motor_abrir(motor_abrir), .motor_cerrar(motor_cerrar), .verde(verde), .rojo(rojo),
        .rechazo(rechazo), .alarma(alarma), .estado(estado), .aperturas(aperturas)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_ap = 0; m_prev = 0; m_rech = 0;
    endtask

    task automatic model_step();
        int nst = m_st;
        bit rch = 0;
        if (fin_abierta && fin_cerrada && m_st != 4) nst = 4;
        else if (m_st == 0) begin
            if (solicitud && !m_prev) begin
                if (count < 7) begin nst = 1; m_ap = (m_ap < 255) ? m_ap + 1 : 255; end
                else rch = 1;
            end
        end else if (m_st == 1) begin
            if (fin_abierta) nst = 2; else if (m_tmr + 1 == TM) nst = 4;
        end else if (m_st == 2) begin
            if (ingreso || m_tmr + 1 == TE) nst = 3;
        end else if (m_st == 3) begin
            if (a) nst = 1; else if (fin_cerrada) nst = 0; else if (m_tmr + 1 == TM) nst = 4;
        end else if (m_st == 4) begin
            if (reconocer && !(fin_abierta && fin_cerrada)) nst = 3;
        end
        m_tmr  = (nst != m_st || m_st == 0 || m_st == 4) ? 0 : m_tmr + 1;
        m_prev = solicitud;
        m_rech = rch;
        m_st   = nst;
    endtask

    // advance one clock; inputs change only after the negedge return
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic open_gate();
        count = 3'($urandom_range(0, 6));
        solicitud = 1; tick(); solicitud = 0;
        fin_abierta = 1; tick(); fin_abierta = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        checks++; if ({motor_abrir, motor_cerrar, verde, rojo, alarma, rechazo} !== 6'b000100) begin
            errors++; $display("FAIL reset_outs got=%b exp=000100", {motor_abrir, motor_cerrar, verde, rojo, alarma, rechazo}); end
        checks++; if (aperturas !== 8'd0) begin errors++; $display("FAIL reset_aperturas got=%0d exp=0", aperturas); end
        rst = 0;
        model_reset();
    endtask

    task automatic test_full_lot();
        int pulses = 0;
        count = 3'd7;
        solicitud = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rechazo) pulses++;
            checks++; if (estado !== 3'd0 || rojo !== 1'b1) begin
                errors++; $display("FAIL full_estado cyc=%0d got=%0d rojo=%b exp=0 rojo=1", i, estado, rojo); end
            checks++; if (rechazo !== m_rech) begin errors++; $display("FAIL full_rechazo cyc=%0d got=%b exp=%b", i, rechazo, m_rech); end
        end
        solicitud = 0; tick();
        checks++; if (pulses != 1) begin errors++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
        checks++; if (aperturas !== 8'd0) begin errors++; $display("FAIL full_aperturas got=%0d exp=0", aperturas); end
    endtask

    task automatic test_normal_entry();
        int abrir_cyc = 0;
        int wait_c = $urandom_range(0, 5);
        count = 3'($urandom_range(0, 6));
        solicitud = 1; tick(); solicitud = 0;
        if (motor_abrir) abrir_cyc++;
        checks++; if (estado !== 3'd1) begin errors++; $display("FAIL norm_abriendo got=%0d exp=1", estado); end
        tick(); if (motor_abrir) abrir_cyc++;
        fin_abierta = 1; tick(); fin_abierta = 0; if (motor_abrir) abrir_cyc++;
        checks++; if (abrir_cyc != 2) begin errors++; $display("FAIL norm_abrir_cycles got=%0d exp=2", abrir_cyc); end
        for (int i = 0; i <= wait_c; i++) begin
            checks++; if (estado !== 3'd2 || verde !== 1'b1 || rojo !== 1'b0) begin
                errors++; $display("FAIL norm_abierta cyc=%0d got=%0d verde=%b", i, estado, verde); end
            a = 1'($urandom_range(0, 1));
            if (i < wait_c) tick();
        end
        a = 0; ingreso = 1; tick(); ingreso = 0;
        checks++; if (estado !== 3'd3 || verde !== 1'b0 || motor_cerrar !== 1'b1) begin
            errors++; $display("FAIL norm_cerrando got=%0d verde=%b mc=%b", estado, verde, motor_cerrar); end
        fin_cerrada = 1; tick(); fin_cerrada = 0;
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL norm_cerrada got=%0d exp=0", estado); end
        checks++; if (aperturas !== 8'd1 || aperturas !== 8'(m_ap)) begin
            errors++; $display("FAIL norm_aperturas got=%0d exp=1", aperturas); end
    endtask

    task automatic test_reversal_and_wait_timeout();
        int n = 0;
        int ap0;
        open_gate();
        ap0 = m_ap;
        ingreso = 1; tick(); ingreso = 0;
        repeat ($urandom_range(0, 3)) tick();
        a = 1; tick(); a = 0;
        checks++; if (estado !== 3'd1 || motor_abrir !== 1'b1 || motor_cerrar !== 1'b0) begin
            errors++; $display("FAIL rev_abriendo got=%0d ma=%b mc=%b", estado, motor_abrir, motor_cerrar); end
        checks++; if (aperturas !== 8'(ap0)) begin errors++; $display("FAIL rev_aperturas got=%0d exp=%0d", aperturas, ap0); end
        fin_abierta = 1; tick(); fin_abierta = 0;
        checks++; if (estado !== 3'd2) begin errors++; $display("FAIL rev_abierta got=%0d exp=2", estado); end
        // fresh timer implies the full T_ESPERA window in ABIERTA
        n = 1;
        while (estado == 3'd2 && n < 20) begin tick(); if (estado == 3'd2) n++; end
        checks++; if (n != TE || estado !== 3'd3) begin
            errors++; $display("FAIL wait_timeout cycles=%0d estado=%0d exp=%0d/3", n, estado, TE); end
        fin_cerrada = 1; tick(); fin_cerrada = 0;
        checks++; if (estado !== 3'(m_st)) begin errors++; $display("FAIL rev_close got=%0d exp=%0d", estado, m_st); end
    endtask

    task automatic test_motor_timeout();
        int n = 0;
        count = 3'($urandom_range(0, 6));
        solicitud = 1; tick(); solicitud = 0;
        while (estado == 3'd1 && n < 20) begin n++; tick(); end
        checks++; if (n != TM || estado !== 3'd4) begin
            errors++; $display("FAIL motor_timeout cycles=%0d estado=%0d exp=%0d/4", n, estado, TM); end
        checks++; if (alarma !== 1'b1 || motor_abrir !== 1'b0 || motor_cerrar !== 1'b0) begin
            errors++; $display("FAIL falla_outs al=%b ma=%b mc=%b exp=1/0/0", alarma, motor_abrir, motor_cerrar); end
        repeat ($urandom_range(1, 4)) tick();
        checks++; if (estado !== 3'd4) begin errors++; $display("FAIL falla_latched got=%0d exp=4", estado); end
        reconocer = 1; tick(); reconocer = 0;
        checks++; if (estado !== 3'd3 || alarma !== 1'b0) begin
            errors++; $display("FAIL ack got=%0d al=%b exp=3/0", estado, alarma); end
        fin_cerrada = 1; tick(); fin_cerrada = 0;
        checks++; if (estado !== 3'(m_st)) begin errors++; $display("FAIL ack_close got=%0d exp=%0d", estado, m_st); end
    endtask

    task automatic test_sensor_fault();
        open_gate();
        fin_abierta = 1; fin_cerrada = 1; tick();
        checks++; if (estado !== 3'd4) begin errors++; $display("FAIL sens_falla got=%0d exp=4", estado); end
        reconocer = 1; tick();
        checks++; if (estado !== 3'd4) begin errors++; $display("FAIL sens_ack_blocked got=%0d exp=4", estado); end
        fin_abierta = 0; fin_cerrada = 0; tick(); reconocer = 0;
        checks++; if (estado !== 3'd3 || estado !== 3'(m_st)) begin
            errors++; $display("FAIL sens_ack got=%0d exp=3", estado); end
        fin_cerrada = 1; tick(); fin_cerrada = 0;
    endtask

    task automatic test_async_reset();
        count = 3'($urandom_range(0, 6));
        solicitud = 1; tick(); solicitud = 0;
        tick();
        #2 rst = 1;
        #1;
        checks++; if (motor_abrir !== 1'b0 || estado !== 3'd0 || aperturas !== 8'd0 || alarma !== 1'b0) begin
            errors++; $display("FAIL async_rst ma=%b estado=%0d ap=%0d al=%b exp=0/0/0/0", motor_abrir, estado, aperturas, alarma); end
        #1 rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (estado !== 3'd0 || motor_abrir !== 1'b0 || motor_cerrar !== 1'b0) begin
                errors++; $display("FAIL post_rst cyc=%0d estado=%0d", i, estado); end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 260; k++) begin
            open_gate();
            ingreso = 1; tick(); ingreso = 0;
            fin_cerrada = 1; tick(); fin_cerrada = 0;
            if (k == 100) begin
                checks++; if (aperturas !== 8'(m_ap)) begin errors++; $display("FAIL sat_mid got=%0d exp=%0d", aperturas, m_ap); end
            end
        end
        checks++; if (aperturas !== 8'd255 || m_ap != 255) begin
            errors++; $display("FAIL saturation got=%0d exp=255", aperturas); end
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL sat_estado got=%0d exp=0", estado); end
    endtask

    initial begin
        test_reset();
        test_full_lot();
        test_normal_entry();
        test_reversal_and_wait_timeout();
        test_motor_timeout();
        test_sensor_fault();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
